// File: rtl/frv_bram_arbiter.sv
// Two-port arbiter in front of a single-port BRAM. Port 1 has priority over port 0.
// With FRV_BRAM_ARB_FAIR_EN defined, a starve counter lifts port 0 above port 1 after STARVE_LIMIT denials.
module frv_bram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        p0_req,
    input  logic        p0_wen,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wstrb,
    output logic        p0_gnt,
    output logic        p0_recv,
    output logic [31:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_wen,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wstrb,
    output logic        p1_gnt,
    output logic        p1_recv,
    output logic [31:0] p1_rdata,

    output logic        bram_cen,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata
);

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("frv_bram_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic p0_prio;
    logic rsp_valid;
    logic rsp_sel;

`ifdef FRV_BRAM_ARB_FAIR_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    assign p0_prio = p0_req && (starve_cnt == LIMIT);

    // Counts only while port 0 waits; any grant or a dropped request restarts it.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            starve_cnt <= 4'd0;
        end else if (!p0_req || p0_gnt) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`else
    assign p0_prio = 1'b0;
`endif

    assign p1_gnt = p1_req && !p0_prio;
    assign p0_gnt = p0_req && (!p1_req || p0_prio);

    assign bram_cen   = p0_gnt | p1_gnt;
    assign bram_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign bram_wdata = p1_gnt ? p1_wdata : p0_wdata;

    always_comb begin
        bram_wstrb = 4'b0000;
        if (p1_gnt && p1_wen) begin
            bram_wstrb = p1_wstrb;
        end else if (p0_gnt && p0_wen) begin
            bram_wstrb = p0_wstrb;
        end
    end

    // rsp_sel records which port owns the data BRAM returns next cycle.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rsp_valid <= 1'b0;
            rsp_sel   <= 1'b0;
        end else begin
            rsp_valid <= bram_cen;
            rsp_sel   <= p1_gnt;
        end
    end

    assign p0_recv  = rsp_valid && !rsp_sel;
    assign p1_recv  = rsp_valid &&  rsp_sel;
    assign p0_rdata = p0_recv ? bram_rdata : 32'd0;
    assign p1_rdata = p1_recv ? bram_rdata : 32'd0;

endmodule

// File: tb/tb_frv_bram_arbiter.sv
// Directed bench for frv_bram_arbiter with a behavioural BRAM (one-cycle read latency, byte strobes).
// Starvation expectations follow FRV_BRAM_ARB_FAIR_EN.
module tb_frv_bram_arbiter;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        p0_req = 1'b0, p0_wen = 1'b0;
    logic [31:0] p0_addr = 32'd0, p0_wdata = 32'd0;
    logic [3:0]  p0_wstrb = 4'd0;
    logic        p0_gnt, p0_recv;
    logic [31:0] p0_rdata;
    logic        p1_req = 1'b0, p1_wen = 1'b0;
    logic [31:0] p1_addr = 32'd0, p1_wdata = 32'd0;
    logic [3:0]  p1_wstrb = 4'd0;
    logic        p1_gnt, p1_recv;
    logic [31:0] p1_rdata;
    logic        bram_cen;
    logic [31:0] bram_addr, bram_wdata;
    logic [3:0]  bram_wstrb;
    logic [31:0] bram_rdata = 32'd0;

    int compared = 0;
    int mismatched = 0;

`ifdef FRV_BRAM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    frv_bram_arbiter #(.STARVE_LIMIT(4)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_wstrb(p0_wstrb), .p0_gnt(p0_gnt), .p0_recv(p0_recv), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_wstrb(p1_wstrb), .p1_gnt(p1_gnt), .p1_recv(p1_recv), .p1_rdata(p1_rdata),
        .bram_cen(bram_cen), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_wstrb(bram_wstrb), .bram_rdata(bram_rdata)
    );

    always #5 g_clk = ~g_clk;

    logic [31:0] mem [0:255];

    // Read returns the pre-write contents; writes land at the same edge.
    always @(posedge g_clk) begin
        if (bram_cen) begin
            bram_rdata <= mem[bram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (bram_wstrb[b]) mem[bram_addr[9:2]][b*8 +: 8] <= bram_wdata[b*8 +: 8];
        end
    end

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle_all();
        p0_req = 1'b0; p0_wen = 1'b0; p0_wstrb = 4'd0;
        p1_req = 1'b0; p1_wen = 1'b0; p1_wstrb = 4'd0;
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if (p0_recv !== 1'b0 || p1_recv !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_recv: got p0=%b p1=%b want 0 0", p0_recv, p1_recv);
        end
        compared++;
        if (p0_rdata !== 32'd0 || p1_rdata !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_rdata: got p0=%h p1=%h want 0 0", p0_rdata, p1_rdata);
        end
        tick();
        g_resetn = 1'b1;
        tick();
        compared++;
        if (bram_cen !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_cen_idle: got %b want 0", bram_cen);
        end
    endtask

    task automatic test_single_read(input string tag);
        p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h10; p0_wstrb = 4'hF;
        #1;
        compared++;
        if (p0_gnt !== 1'b1 || p1_gnt !== 1'b0 || bram_cen !== 1'b1) begin
            mismatched++;
            $display("FAIL %s_gnt: got p0_gnt=%b p1_gnt=%b cen=%b want 1 0 1", tag, p0_gnt, p1_gnt, bram_cen);
        end
        compared++;
        if (bram_addr !== 32'h10 || bram_wstrb !== 4'b0000) begin
            mismatched++;
            $display("FAIL %s_bram: got addr=%h wstrb=%b want 10 0000", tag, bram_addr, bram_wstrb);
        end
        tick();
        idle_all();
        compared++;
        if (p0_recv !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_recv !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_recv: got p0_recv=%b rdata=%h p1_recv=%b want 1 deadbeef 0",
                     tag, p0_recv, p0_rdata, p1_recv);
        end
        tick();
        compared++;
        if (p0_recv !== 1'b0 || p0_rdata !== 32'd0) begin
            mismatched++;
            $display("FAIL %s_pulse: got p0_recv=%b rdata=%h want 0 0", tag, p0_recv, p0_rdata);
        end
    endtask

    task automatic test_collision();
        p0_req = 1'b1; p0_addr = 32'h10; p0_wen = 1'b0;
        p1_req = 1'b1; p1_addr = 32'h14; p1_wen = 1'b0;
        #1;
        compared++;
        if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0 || bram_addr !== 32'h14) begin
            mismatched++;
            $display("FAIL coll_first: got p1_gnt=%b p0_gnt=%b addr=%h want 1 0 14", p1_gnt, p0_gnt, bram_addr);
        end
        tick();
        p1_req = 1'b0;
        #1;
        compared++;
        if (p0_gnt !== 1'b1 || p1_recv !== 1'b1 || p1_rdata !== 32'hCAFEF00D || p0_recv !== 1'b0) begin
            mismatched++;
            $display("FAIL coll_second: got p0_gnt=%b p1_recv=%b p1_rdata=%h p0_recv=%b want 1 1 cafef00d 0",
                     p0_gnt, p1_recv, p1_rdata, p0_recv);
        end
        tick();
        idle_all();
        compared++;
        if (p0_recv !== 1'b1 || p0_rdata !== 32'hDEADBEEF || p1_recv !== 1'b0) begin
            mismatched++;
            $display("FAIL coll_third: got p0_recv=%b p0_rdata=%h p1_recv=%b want 1 deadbeef 0",
                     p0_recv, p0_rdata, p1_recv);
        end
        tick();
    endtask

    task automatic test_write_read();
        p1_req = 1'b1; p1_wen = 1'b1; p1_wstrb = 4'b0011; p1_addr = 32'h20; p1_wdata = 32'h12345678;
        #1;
        compared++;
        if (p1_gnt !== 1'b1 || bram_wstrb !== 4'b0011 || bram_wdata !== 32'h12345678) begin
            mismatched++;
            $display("FAIL wr_bram: got gnt=%b wstrb=%b wdata=%h want 1 0011 12345678", p1_gnt, bram_wstrb, bram_wdata);
        end
        tick();
        idle_all();
        p0_req = 1'b1; p0_wen = 1'b0; p0_wstrb = 4'hF; p0_addr = 32'h20; p0_wdata = 32'hFFFFFFFF;
        #1;
        compared++;
        if (p0_gnt !== 1'b1 || bram_wstrb !== 4'b0000 || p1_recv !== 1'b1) begin
            mismatched++;
            $display("FAIL rd_bram: got gnt=%b wstrb=%b p1_recv=%b want 1 0000 1", p0_gnt, bram_wstrb, p1_recv);
        end
        tick();
        idle_all();
        compared++;
        if (p0_recv !== 1'b1 || p0_rdata !== 32'h00005678) begin
            mismatched++;
            $display("FAIL rd_data: got recv=%b rdata=%h want 1 00005678", p0_recv, p0_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        int p0_grants = 0;
        logic exp_p0;
        p1_req = 1'b1; p1_wen = 1'b0; p1_addr = 32'h14;
        p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h10;
        for (int k = 1; k <= 12; k++) begin
            #1;
            exp_p0 = FAIR && (k == 5);
            compared++;
            if (p0_gnt !== exp_p0 || p1_gnt !== !exp_p0) begin
                mismatched++;
                $display("FAIL starve_cycle%0d: got p0_gnt=%b p1_gnt=%b want %b %b",
                         k, p0_gnt, p1_gnt, exp_p0, !exp_p0);
            end
            if (p0_gnt === 1'b1) p0_grants++;
            tick();
            if (exp_p0) p0_req = 1'b0;
        end
        compared++;
        if (p0_grants != (FAIR ? 1 : 0)) begin
            mismatched++;
            $display("FAIL starve_total: got %0d p0 grants want %0d", p0_grants, FAIR ? 1 : 0);
        end
        idle_all();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        p0_req = 1'b1; p0_addr = 32'h10;
        p1_req = 1'b1; p1_addr = 32'h14;
        repeat (3) tick();
        #1;
        compared++;
        if (p1_gnt !== 1'b1) begin
            mismatched++;
            $display("FAIL rstmid_pre: got p1_gnt=%b want 1", p1_gnt);
        end
        @(posedge g_clk);
        g_resetn = 1'b0;
        idle_all();
        #1;
        compared++;
        if (p1_recv !== 1'b0 || p1_rdata !== 32'd0) begin
            mismatched++;
            $display("FAIL rstmid_drop: got p1_recv=%b p1_rdata=%h want 0 0", p1_recv, p1_rdata);
        end
        tick();
        g_resetn = 1'b1;
        tick();
        compared++;
        if (p1_recv !== 1'b0 || p0_recv !== 1'b0 || bram_cen !== 1'b0) begin
            mismatched++;
            $display("FAIL rstmid_after: got p1_recv=%b p0_recv=%b cen=%b want 0 0 0", p1_recv, p0_recv, bram_cen);
        end
        // Counter must restart from zero: four more denials before port 0 can win.
        p0_req = 1'b1; p0_addr = 32'h10;
        p1_req = 1'b1; p1_addr = 32'h14;
        for (int k = 1; k <= 4; k++) begin
            #1;
            compared++;
            if (p1_gnt !== 1'b1 || p0_gnt !== 1'b0) begin
                mismatched++;
                $display("FAIL rstmid_cnt%0d: got p1_gnt=%b p0_gnt=%b want 1 0", k, p1_gnt, p0_gnt);
            end
            tick();
        end
        idle_all();
        tick();
        tick();
        test_single_read("postrst");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h04] = 32'hDEADBEEF;
        mem[8'h05] = 32'hCAFEF00D;
        test_reset();
        test_single_read("single");
        test_collision();
        test_write_read();
        test_starvation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/frv_bram_arbiter.md
FRV_BRAM_ARBITER -- requirements
Module: frv_bram_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive cycles port 0 may be denied while requesting before it takes priority (range 1..15).
REQ-002 SHALL have port: g_clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: g_resetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports, for p in {0,1}: p_req input 1 request; p_wen input 1 write enable; p_addr input 32 byte address; p_wdata input 32 write data; p_wstrb input 4 byte strobes; p_gnt output 1 request accepted this cycle; p_recv output 1 response valid; p_rdata output 32 read data. Ports are named p0_* and p1_*.
REQ-005 SHALL have BRAM-side ports: bram_cen output 1; bram_addr output 32; bram_wdata output 32; bram_wstrb output 4; bram_rdata input 32 (valid one cycle after bram_cen).

Function
REQ-006 SHALL grant at most one port per cycle; pN_gnt is combinational from the current pN_req and arbiter state.
REQ-007 SHALL drive bram_cen = p0_gnt | p1_gnt, and take bram_addr/bram_wdata from the granted port (port 0 when neither is granted).
REQ-008 SHALL drive bram_wstrb = granted port's wstrb when its wen=1, else 4'b0000 (reads never write).
REQ-009 SHALL use default priority port 1 over port 0.
REQ-010 SHALL keep a 4-bit starve counter: +1 each cycle p0_req=1 and p0_gnt=0; cleared when p0_gnt=1 or p0_req=0; saturates at STARVE_LIMIT.
REQ-011 SHALL, when starve counter == STARVE_LIMIT and p0_req=1, grant port 0 over port 1 for that cycle.
REQ-012 SHALL register rsp_valid and rsp_sel (granted port index) at every grant; rsp_valid=0 in cycles with no grant.
REQ-013 SHALL assert pN_recv for exactly one cycle, the cycle after pN_gnt, for reads and writes alike; pN_rdata = bram_rdata in that cycle, 0 otherwise.
REQ-014 SHALL support back-to-back grants (to either port) every cycle; grant and response of different transactions overlap without bubbles.
REQ-015 SHALL hold no backpressure on responses; requesters accept pN_recv unconditionally.
REQ-016 SHALL not let an unaccepted requester's inputs affect the BRAM; requesters hold req and payload stable until gnt.
REQ-017 SHALL keep state-independent behaviour when only one port requests: that port is granted the same cycle.

Reset
REQ-018 SHALL, while g_resetn=0, clear starve counter, rsp_valid and rsp_sel asynchronously; p0_recv=p1_recv=0, p0_rdata=p1_rdata=0.
REQ-019 SHALL drop any response in flight when reset asserts mid-transaction; no recv is produced for it after reset release.
REQ-020 SHALL keep gnt and BRAM outputs combinational; with req inputs low after reset, bram_cen=0.

Configuration
REQ-021 SHALL compile the starvation logic (REQ-010, REQ-011) only when macro FRV_BRAM_ARB_FAIR_EN is defined.
REQ-022 SHALL, without FRV_BRAM_ARB_FAIR_EN, implement strict priority port 1 over port 0, with no starve counter and STARVE_LIMIT ignored.

Verification
REQ-023 SHALL test: only p0 reads addr 0x10 (BRAM holds 0xDEADBEEF) -> p0_gnt same cycle, p0_recv next cycle with p0_rdata=0xDEADBEEF, p1_recv=0.
REQ-024 SHALL test: p0 and p1 request together once -> p1_gnt first, p0_gnt next cycle, recv pulses p1 then p0 on consecutive cycles.
REQ-025 SHALL test: p1 requests continuously, p0 requests, STARVE_LIMIT=4, FAIR_EN defined -> p0 granted on its 5th requesting cycle, then p1 resumes; without macro -> p0 never granted.
REQ-026 SHALL test: p1 write wen=1 wstrb=4'b0011 data 0x12345678 at 0x20, then p0 read 0x20 -> bram_wstrb=4'b0011 on write, bram_wstrb=0 on read, p0_rdata=0x00005678 (BRAM initially zero).
REQ-027 SHALL test: g_resetn low in cycle after p1_gnt -> p1_recv stays 0, counter 0, first post-reset request behaves as REQ-023.
